// File: rtl/cache_pkg.sv
// Shared cache constants and types used by the cache and its line-fill engine.
package cache_pkg;

  localparam int NrWordsPerLine = 4;
  localparam int ByteOffsetBits = 4;
  localparam int LineSize       = 32 * NrWordsPerLine;

  typedef logic [NrWordsPerLine-1:0][31:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } fill_state_e;

endpackage

// File: rtl/line_fill_unit.sv
// Line-fill engine: fetches one cache line word by word over a req/gnt/rvalid
// memory port and hands the assembled line back to the cache with a valid pulse.
module line_fill_unit
  import cache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [31:0]         mem_addr_i,
  input  logic                mem_read_en_i,
  output logic                mem_read_valid_o,
  output logic [LineSize-1:0] mem_read_data_o,
  output logic                ram_req_o,
  output logic [31:0]         ram_addr_o,
  input  logic                ram_gnt_i,
  input  logic                ram_rvalid_i,
  input  logic [31:0]         ram_rdata_i,
  output logic                busy_o
);

  localparam int                  BeatBits = $clog2(NrWordsPerLine);
  localparam logic [BeatBits-1:0] LastBeat = BeatBits'(NrWordsPerLine - 1);

  fill_state_e         state_q, state_d;
  logic [31:0]         base_q, base_d;
  logic [BeatBits-1:0] beat_q, beat_d;
  logic                abort_q, abort_d;
  line_t               line_q, line_d;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    abort_d = abort_q;
    line_d  = line_q;

    case (state_q)
      IDLE: begin
        if (mem_read_en_i) begin
          base_d  = {mem_addr_i[31:ByteOffsetBits], {ByteOffsetBits{1'b0}}};
          beat_d  = '0;
          abort_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!mem_read_en_i) abort_d = 1'b1;
        if (ram_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (!mem_read_en_i) abort_d = 1'b1;
        // An abort only takes effect once the outstanding beat has returned.
        if (ram_rvalid_i) begin
          line_d[beat_q] = ram_rdata_i;
          if (abort_q) begin
            state_d = IDLE;
          end else if (beat_q == LastBeat) begin
            state_d = RESP;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      abort_q <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      abort_q <= abort_d;
      line_q  <= line_d;
    end
  end

  // Outputs depend only on registered state, never directly on inputs.
  assign ram_req_o        = (state_q == REQ);
  assign ram_addr_o       = ram_req_o ? (base_q + 32'({beat_q, 2'b00})) : '0;
  assign mem_read_valid_o = (state_q == RESP);
  assign mem_read_data_o  = line_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: the bench acts as the memory, using a
// per-beat delay plan, and predicts addresses, latency and the returned line.
module tb_line_fill_unit;
  import cache_pkg::*;

  logic                clk_i = 1'b0;
  logic                rstn_i = 1'b0;
  logic [31:0]         mem_addr_i = '0;
  logic                mem_read_en_i = 1'b0;
  logic                mem_read_valid_o;
  logic [LineSize-1:0] mem_read_data_o;
  logic                ram_req_o;
  logic [31:0]         ram_addr_o;
  logic                ram_gnt_i = 1'b0;
  logic                ram_rvalid_i = 1'b0;
  logic [31:0]         ram_rdata_i = '0;
  logic                busy_o;

  line_fill_unit dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .mem_addr_i       (mem_addr_i),
    .mem_read_en_i    (mem_read_en_i),
    .mem_read_valid_o (mem_read_valid_o),
    .mem_read_data_o  (mem_read_data_o),
    .ram_req_o        (ram_req_o),
    .ram_addr_o       (ram_addr_o),
    .ram_gnt_i        (ram_gnt_i),
    .ram_rvalid_i     (ram_rvalid_i),
    .ram_rdata_i      (ram_rdata_i),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: words to return, per-beat gnt and rvalid delays.
  logic [31:0] word_src [NrWordsPerLine];
  int          cfg_gd   [NrWordsPerLine];
  int          cfg_rd   [NrWordsPerLine];
  logic [31:0] exp_base;
  int          beat_m, gnt_left, rv_left;
  bit          rv_pend, stall_active, stray_en;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic line_t model_line();
    line_t l;
    for (int k = 0; k < NrWordsPerLine; k++) l[k] = word_src[k];
    return l;
  endfunction

  function automatic int model_latency();
    int lat = 1 + 2 * NrWordsPerLine;
    for (int k = 0; k < NrWordsPerLine; k++) lat += cfg_gd[k] + cfg_rd[k];
    return lat;
  endfunction

  task automatic set_plan(input int max_gd, input int min_rd, input int max_rd);
    for (int k = 0; k < NrWordsPerLine; k++) begin
      word_src[k] = $urandom;
      cfg_gd[k]   = $urandom_range(max_gd, 0);
      cfg_rd[k]   = $urandom_range(max_rd, min_rd);
    end
  endtask

  task automatic init_model(input logic [31:0] addr);
    exp_base     = {addr[31:4], 4'h0};
    beat_m       = 0;
    rv_pend      = 1'b0;
    stall_active = 1'b0;
    gnt_left     = cfg_gd[0];
    rv_left      = 0;
  endtask

  // Observe the DUT after an edge and choose memory inputs for the next edge.
  task automatic mem_drive();
    ram_gnt_i    = 1'b0;
    ram_rvalid_i = 1'b0;
    ram_rdata_i  = $urandom;
    if (stall_active) begin
      n_checks++;
      if (ram_req_o !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL req_held_until_gnt: ram_req_o=%b required 1", ram_req_o);
      end
    end
    if (rv_pend) begin
      n_checks++;
      if (ram_req_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL single_outstanding: ram_req_o=%b required 0", ram_req_o);
      end
      if (stray_en) ram_gnt_i = 1'b1;
      if (rv_left == 0) begin
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = word_src[beat_m];
        rv_pend      = 1'b0;
        beat_m++;
        if (beat_m < NrWordsPerLine) gnt_left = cfg_gd[beat_m];
      end else begin
        rv_left--;
      end
    end else if (ram_req_o === 1'b1) begin
      n_checks++;
      if (ram_addr_o !== exp_base + 32'(4 * beat_m)) begin
        n_fail++;
        $display("[TB] FAIL beat_addr: ram_addr_o=%h required %h", ram_addr_o,
                 exp_base + 32'(4 * beat_m));
      end
      if (stray_en) ram_rvalid_i = 1'b1;
      if (gnt_left > 0) begin
        gnt_left--;
        stall_active = 1'b1;
      end else begin
        ram_gnt_i    = 1'b1;
        rv_pend      = 1'b1;
        rv_left      = cfg_rd[beat_m];
        stall_active = 1'b0;
      end
    end
  endtask

  // Runs one fill from IDLE; abort_beat >= 0 drops the request in that beat's WAIT.
  task automatic run_fill(input logic [31:0] addr, input int abort_beat, input bit hold_en,
                          input bit strays, output int lat, output line_t data);
    int cyc;
    bit done;
    stray_en = strays;
    init_model(addr);
    mem_addr_i    = addr;
    mem_read_en_i = 1'b1;
    lat  = -1;
    data = '0;
    step();
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 400) begin
      if (abort_beat >= 0 && beat_m > abort_beat) begin
        done = 1'b1;
        ram_gnt_i    = 1'b0;
        ram_rvalid_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || ram_req_o !== 1'b0 || mem_read_valid_o !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL abort_to_idle: busy=%b req=%b valid=%b required 0/0/0",
                   busy_o, ram_req_o, mem_read_valid_o);
        end
      end else begin
        n_checks++;
        if (busy_o !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL busy_in_fill: busy_o=%b required 1 at cycle %0d", busy_o, cyc);
        end
        if (mem_read_valid_o === 1'b1) begin
          done = 1'b1;
          lat  = cyc;
          data = mem_read_data_o;
          ram_gnt_i    = 1'b0;
          ram_rvalid_i = 1'b0;
          n_checks += 3;
          if (abort_beat >= 0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_valid: valid pulse seen, required none");
          end
          if (mem_read_data_o !== model_line()) begin
            n_fail++;
            $display("[TB] FAIL line_data: got %h required %h", mem_read_data_o, model_line());
          end
          if (cyc != model_latency() || beat_m != NrWordsPerLine) begin
            n_fail++;
            $display("[TB] FAIL latency: got %0d cycles (%0d beats) required %0d (%0d beats)",
                     cyc, beat_m, model_latency(), NrWordsPerLine);
          end
          if (!hold_en) mem_read_en_i = 1'b0;
          step();
          n_checks++;
          if (mem_read_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pulse_then_idle: valid=%b busy=%b required 0/0",
                     mem_read_valid_o, busy_o);
          end
        end else begin
          mem_drive();
          if (abort_beat >= 0 && rv_pend && beat_m == abort_beat && ram_req_o === 1'b0)
            mem_read_en_i = 1'b0;
          if (mem_read_en_i) mem_addr_i = $urandom;
          step();
          cyc++;
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL fill_timeout: no completion after %0d cycles, required done", cyc);
      mem_read_en_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    step();
    step();
    n_checks += 5;
    if (ram_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b required 0", ram_req_o); end
    if (ram_addr_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h required 0", ram_addr_o); end
    if (mem_read_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b required 0", mem_read_valid_o); end
    if (mem_read_data_o !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %h required 0", mem_read_data_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b required 0", busy_o); end
    rstn_i = 1'b1;
    step();
  endtask

  task automatic test_zero_wait();
    int lat;
    line_t data, want;
    want = 128'h000000A3_000000A2_000000A1_000000A0;
    for (int k = 0; k < NrWordsPerLine; k++) begin
      word_src[k] = 32'hA0 + 32'(k);
      cfg_gd[k]   = 0;
      cfg_rd[k]   = 0;
    end
    run_fill(32'h0000_1234, -1, 1'b0, 1'b0, lat, data);
    n_checks += 2;
    if (lat != 9) begin n_fail++; $display("[TB] FAIL zero_wait_latency: got %0d required 9", lat); end
    if (data !== want) begin n_fail++; $display("[TB] FAIL zero_wait_data: got %h required %h", data, want); end
  endtask

  task automatic test_wait_states();
    int lat;
    line_t data;
    set_plan(0, 0, 0);
    cfg_gd[1] = 2;
    cfg_rd[1] = 3;
    run_fill($urandom, -1, 1'b0, 1'b0, lat, data);
    n_checks++;
    if (lat != 14) begin n_fail++; $display("[TB] FAIL wait_state_latency: got %0d required 14", lat); end
  endtask

  task automatic test_abort();
    int lat;
    line_t data;
    set_plan(1, 0, 1);
    cfg_rd[1] = 2;
    run_fill(32'h0000_4448, 1, 1'b0, 1'b0, lat, data);
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (ram_req_o !== 1'b0 || mem_read_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL abort_quiet: req=%b valid=%b busy=%b required 0/0/0",
                 ram_req_o, mem_read_valid_o, busy_o);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    bit found = 1'b0;
    set_plan(0, 0, 0);
    stray_en = 1'b0;
    init_model(32'h0000_5A58);
    mem_addr_i    = 32'h0000_5A58;
    mem_read_en_i = 1'b1;
    step();
    for (int c = 0; c < 40 && !found; c++) begin
      if (ram_req_o === 1'b1 && beat_m == 2) found = 1'b1;
      else begin mem_drive(); step(); end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("[TB] FAIL reach_beat2: beat 2 request not seen, required seen"); end
    rstn_i       = 1'b0;
    ram_gnt_i    = 1'b0;
    ram_rvalid_i = 1'b0;
    step();
    n_checks++;
    if (ram_req_o !== 1'b0 || ram_addr_o !== 32'h0 || mem_read_valid_o !== 1'b0 ||
        busy_o !== 1'b0 || mem_read_data_o !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_fill_reset: req=%b addr=%h valid=%b busy=%b data=%h required all 0",
               ram_req_o, ram_addr_o, mem_read_valid_o, busy_o, mem_read_data_o);
    end
    rstn_i        = 1'b1;
    mem_read_en_i = 1'b0;
    ram_rvalid_i  = 1'b1;
    ram_rdata_i   = 32'hDEAD_BEEF;
    step();
    ram_rvalid_i = 1'b0;
    step();
    n_checks++;
    if (ram_req_o !== 1'b0 || mem_read_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        mem_read_data_o !== '0) begin
      n_fail++;
      $display("[TB] FAIL stray_rvalid_idle: req=%b valid=%b busy=%b data=%h required all 0",
               ram_req_o, mem_read_valid_o, busy_o, mem_read_data_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    line_t data;
    set_plan(0, 0, 0);
    run_fill(32'h0000_1F04, -1, 1'b1, 1'b0, lat, data);
    set_plan(0, 0, 0);
    run_fill(32'h0000_2000, -1, 1'b0, 1'b0, lat, data);
    n_checks++;
    if (lat != 9) begin n_fail++; $display("[TB] FAIL back_to_back_latency: got %0d required 9", lat); end
  endtask

  task automatic test_stray_inputs();
    int lat;
    line_t data;
    set_plan(2, 1, 3);
    run_fill($urandom, -1, 1'b0, 1'b1, lat, data);
  endtask

  task automatic test_random();
    int lat;
    line_t data;
    for (int i = 0; i < 25; i++) begin
      set_plan(3, 0, 3);
      run_fill($urandom, -1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), lat, data);
    end
    mem_read_en_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_abort();
    test_reset_mid_fill();
    test_zero_wait();
    test_back_to_back();
    test_stray_inputs();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
